// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one bitwise logic unit among NREQ requesters
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester operation valid
//   req_op     2-bit op per requester (00 AND, 01 OR, 10 XOR, 11 ANDN)
//   req_a      WIDTH-bit operand A per requester
//   req_b      WIDTH-bit operand B per requester
//   req_ready  one-hot combinational grant
//   rsp_valid  result register holds a valid result
//   rsp_id     requester that owns rsp_data
//   rsp_data   registered result
//   rsp_ready  consumer accepts the result this cycle
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  input  logic                    rsp_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_after;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   scan_idx;
  logic [IDW:0]     scan_sum;
  logic             found;
  logic             accept_open;
  logic             grant;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH-1:0] result;

  // The result register can take a new value when it is empty or is being
  // drained this very cycle; reset closes the window outright.
  assign accept_open = !rst && ((state == IDLE) || rsp_ready);

  // Rotating priority scan starting at ptr. The extra sum bit lets the wrap
  // be done modulo NREQ, which need not be a power of two.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign grant = accept_open && found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign ptr_after = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  // Shared logic unit, fed by the winner's lane
  assign win_op = req_op[2*int'(winner) +: 2];
  assign win_a  = req_a[WIDTH*int'(winner) +: WIDTH];
  assign win_b  = req_b[WIDTH*int'(winner) +: WIDTH];

  always_comb begin
    result = '0;
    case (win_op)
      2'b00:   result = win_a & win_b;
      2'b01:   result = win_a | win_b;
      2'b10:   result = win_a ^ win_b;
      default: result = win_a & ~win_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant) state_next = HOLD;
      end
      HOLD: begin
        // A grant here is a back-to-back load: the old result drains as the
        // new one arrives, so the register stays full.
        if (grant)          state_next = HOLD;
        else if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (grant) begin
      ptr      <= ptr_after;
      rsp_id   <= winner;
      rsp_data <= result;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - table-driven scoreboard bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [7:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_ready;

  logic_unit_arbiter #(.NREQ(4), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [3:0]   valid;
    logic [7:0]   op;
    logic [127:0] a;
    logic [127:0] b;
    logic         rsp_ready;
    logic [3:0]   exp_ready;
    logic [31:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  localparam logic [7:0]   OPS = 8'b11_10_01_00;
  localparam logic [127:0] RA  = {4{32'h0000FFFF}};
  localparam logic [127:0] RB  = {4{32'h00FF00FF}};

  vec_t tbl[$];
  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_valid = 1'b0;
  logic after_reset = 1'b0;
  logic started = 1'b0;

  function automatic vec_t mk(logic r, logic [3:0] v, logic rr, logic [3:0] er,
                              logic [7:0] op, logic [127:0] a, logic [127:0] b,
                              logic [31:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.rsp_ready = rr; t.exp_ready = er;
    t.op = op; t.a = a; t.b = b; t.exp_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp();
    if (!started) return;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: rsp_valid with no expected entry");
      end else begin
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("rsp_data", rsp_data, sb[0].data);
      end
    end
    if (after_reset) begin
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t v);
    rsp_t e;
    check_rsp();
    started   = 1'b1;
    rst       = v.rst;
    req_valid = v.valid;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = v.rsp_ready;
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
    @(posedge clk);
    if (v.rst) begin
      exp_valid   = 1'b0;
      after_reset = 1'b1;
      sb.delete();
    end else begin
      after_reset = 1'b0;
      if (exp_valid && v.rsp_ready && sb.size() > 0) void'(sb.pop_front());
      if (v.exp_ready != 4'b0000) begin
        e.id = 2'd0;
        for (int i = 0; i < 4; i++) if (v.exp_ready[i]) e.id = 2'(i);
        e.data = v.exp_data;
        sb.push_back(e);
        exp_valid = 1'b1;
      end else if (v.rsp_ready) begin
        exp_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset held for two cycles with everyone requesting
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, OPS, RA, RB, 32'h0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, OPS, RA, RB, 32'h0));
    // Single AND from requester 2
    tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 8'h00, {32'h0, 32'hF0F0F0F0, 64'h0},
                     {32'h0, 32'hFF00FF00, 64'h0}, 32'hF000F000));
    // OR / XOR / ANDN from requester 0, back-to-back
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 8'h01, {96'h0, 32'h0000FFFF},
                     {96'h0, 32'h00FF00FF}, 32'h00FFFFFF));
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 8'h02, {96'h0, 32'h0000FFFF},
                     {96'h0, 32'h00FF00FF}, 32'h00FFFF00));
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 8'h03, {96'h0, 32'h0000FFFF},
                     {96'h0, 32'h00FF00FF}, 32'h0000FF00));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, OPS, RA, RB, 32'h0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, OPS, RA, RB, 32'h0));
    // Requester 3 ANDN; also moves ptr to 0
    tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 8'hC0, {32'hFFFF0000, 96'h0},
                     {32'h0F0F0F0F, 96'h0}, 32'hF0F00000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, OPS, RA, RB, 32'h0));
    // Round-robin with all valid: 0,1,2,3,0
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, OPS, RA, RB, 32'h000000FF));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, OPS, RA, RB, 32'h00FFFFFF));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, OPS, RA, RB, 32'h00FFFF00));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, OPS, RA, RB, 32'h0000FF00));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, OPS, RA, RB, 32'h000000FF));
    // Backpressure: requester 1 result held for 5 cycles
    tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, OPS, RA, RB, 32'h00FFFFFF));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'b1101, 0, 4'b0000, OPS, RA, RB, 32'h0));
    tbl.push_back(mk(0, 4'b1101, 1, 4'b0100, OPS, RA, RB, 32'h00FFFF00));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, OPS, RA, RB, 32'h0));

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i]);

    // Reset while a result is pending and ptr sits at 3
    apply(mk(0, 4'b0100, 0, 4'b0100, OPS, RA, RB, 32'h00FFFF00));
    chk("hold_before_rst", 32'(rsp_valid), 32'd1);
    apply(mk(1, 4'b1111, 0, 4'b0000, OPS, RA, RB, 32'h0));
    chk("rsp_valid_after_rst", 32'(rsp_valid), 32'd0);
    chk("rsp_data_after_rst", rsp_data, 32'd0);
    apply(mk(0, 4'b1111, 1, 4'b0001, OPS, RA, RB, 32'h000000FF));
    apply(mk(0, 4'b0000, 1, 4'b0000, OPS, RA, RB, 32'h0));

    // Request withdrawn while blocked must never be granted
    apply(mk(0, 4'b0010, 0, 4'b0010, OPS, RA, RB, 32'h00FFFFFF));
    apply(mk(0, 4'b1000, 0, 4'b0000, OPS, RA, RB, 32'h0));
    apply(mk(0, 4'b0000, 1, 4'b0000, OPS, RA, RB, 32'h0));
    check_rsp();
    chk("final_idle", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise logic unit (AND, OR, XOR, AND-NOT) among NREQ requesters. It sits between the requesting blocks and the shared logic datapath in the RV32I logic-block layer. It accepts one operation per cycle through a valid/ready handshake and returns a registered result tagged with the requester ID. The response port supports backpressure.

## Interface
Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- WIDTH, 32: operand and result width.
- IDW, ⌈log2 NREQ⌉: derived; width of the requester ID.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  bit i set = requester i presents an operation.
- req_op  in  2*NREQ  op of requester i in bits [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
- req_a  in  WIDTH*NREQ  operand A of requester i in bits [WIDTH*i +: WIDTH].
- req_b  in  WIDTH*NREQ  operand B of requester i, packed the same way as req_a.
- req_ready  out  NREQ  one-hot grant, combinational; at most one bit set per cycle.
- rsp_valid  out  1  result register holds a valid result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  WIDTH  registered result.
- rsp_ready  in  1  consumer accepts the result this cycle.

## Operation
- State machine:
  - IDLE: rsp_valid=0.
  - HOLD: rsp_valid=1.
- Accept window is open when state is IDLE, or when state is HOLD and rsp_ready=1.
- Arbitration:
  - Applies only when the accept window is open and req_valid≠0.
  - The winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, … mod NREQ.
  - req_ready[winner]=1 that cycle; all other bits are 0.
- Handshake:
  - A transfer completes when req_valid[i] & req_ready[i] at the rising edge.
  - Requesters hold op and operands stable until granted.
  - Deasserting req_valid before a grant is legal; that request is dropped.
- On a transfer at edge:
  - rsp_data ← op(a,b) of the winner.
  - rsp_id ← winner.
  - ptr ← (winner+1) mod NREQ.
  - state ← HOLD.
- In HOLD with rsp_ready=1 and no transfer: state ← IDLE; rsp_data and rsp_id keep their values.
- In HOLD with rsp_ready=0:
  - rsp_valid, rsp_id and rsp_data are held stable.
  - req_ready=0 and ptr is unchanged.
- Simultaneous rsp_ready=1 and a new transfer in HOLD: the old result is consumed and the new result loads at the same edge (back-to-back).
- ptr advances only on a transfer, never on idle cycles.
- Arithmetic is purely bitwise on WIDTH bits; there is no carry and no sign extension.
- Reset:
  - rst=1 at an edge forces state←IDLE, ptr←0, rsp_valid←0, rsp_id←0, rsp_data←0.
  - req_ready is forced to 0 while rst=1.
  - A result pending in HOLD is discarded with no response.
- rst has priority over every other event.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0.
- Latency: a request granted in cycle N produces a response with rsp_valid=1 in cycle N+1.
- Throughput: one operation per cycle while rsp_ready=1 is held.
- req_ready depends combinationally on req_valid, state, ptr, rsp_ready and rst. There are no other combinational paths from input to output.
- rsp_* outputs come directly from registers.
- With NREQ requesters continuously valid, each is granted exactly once per NREQ transfers (starvation-free).

## Test plan
- Reset: hold rst=1 for 2 cycles with req_valid=4'b1111 and rsp_ready=1 -> req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0 throughout.
- Single AND: requester 2 only, op=00, a=0xF0F0F0F0, b=0xFF00FF00 -> req_ready=4'b0100 in cycle N; in N+1 rsp_valid=1, rsp_id=2, rsp_data=0xF000F000.
- Ops: requester 0 with a=0x0000FFFF, b=0x00FF00FF and op=01/10/11 -> rsp_data=0x00FFFFFF / 0x00FFFF00 / 0x0000FF00.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grants 0,1,2,3,0 in consecutive cycles and rsp_valid stays 1 from the second cycle.
- Backpressure: result from requester 1 pending, rsp_ready=0 for 5 cycles with req_valid=4'b1101 -> rsp_* stable and req_ready=0 for all 5 cycles; in the rsp_ready=1 cycle req_ready=4'b0100, and the next cycle shows rsp_id=2.
- Reset mid-HOLD: assert rst for 1 cycle while rsp_valid=1 and ptr=3 -> next cycle rsp_valid=0, rsp_data=0; with all requesters valid, the first grant after reset goes to requester 0.
